// File: rtl/fifo_pkg.sv
// fifo_pkg
// Shared definitions for the FIFO drain / serial transmitter slice.
//   DEFAULT_DATA_WIDTH : default word width, must match the FIFO feeding the transmitter
//   FRAMES_W           : width of the completed-frame counter
//   tx_state_t         : transmitter FSM states (PARITY is only reached when
//                        FIFO_TX_PARITY_EN is defined)
package fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int FRAMES_W           = 16;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

endpackage

// File: rtl/tx_bit_timer.sv
// tx_bit_timer
// Baud counter for the serial transmitter. Counts 0..CLKS_PER_BIT-1 and
// flags the terminal count, then wraps.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   clear : restart the count at 0 on the next edge (used on every state entry)
//   tick  : high during the last cycle of each bit period
module tx_bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == CNT_W'(CLKS_PER_BIT - 1));

  // Clearing one cycle before a state change makes the new state start at 0.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fifo_serial_tx.sv
// fifo_serial_tx
// Drains a FIFO one word at a time and shifts each word out as an
// asynchronous serial frame: start bit, data LSB first, optional even
// parity, STOP_BITS stop bits.
// Optional feature macro: FIFO_TX_PARITY_EN (inserts the PARITY state).
// Ports:
//   Clock       : rising-edge clock
//   Reset       : synchronous active-high reset, aborts any frame in flight
//   EN          : drain enable, looked at in IDLE and at the end of a frame
//   Empty       : FIFO empty flag
//   Read_Data   : FIFO read data, valid the cycle after RE
//   RE          : one-cycle FIFO read strobe per word
//   Tx          : serial line, idles high
//   Busy        : high whenever the FSM is not in IDLE
//   Frames_Sent : completed-frame count, wraps
module fifo_serial_tx
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int CLKS_PER_BIT = 4,
  parameter int STOP_BITS    = 1
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  EN,
  input  logic                  Empty,
  input  logic [DATA_WIDTH-1:0] Read_Data,
  output logic                  RE,
  output logic                  Tx,
  output logic                  Busy,
  output logic [FRAMES_W-1:0]   Frames_Sent
);

  localparam int BIT_CNT_W = $clog2(DATA_WIDTH + 1);

  tx_state_t             state;
  tx_state_t             state_next;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic                  stop_cnt;
  logic                  tick;
  logic                  timer_clear;
  logic                  frame_done;
  logic                  last_bit;
  logic                  last_stop;
`ifdef FIFO_TX_PARITY_EN
  logic                  parity_bit;
`endif

  assign last_bit    = (bit_cnt == BIT_CNT_W'(DATA_WIDTH - 1));
  assign last_stop   = (stop_cnt == 1'(STOP_BITS - 1));
  assign timer_clear = (state_next != state);

  tx_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk   (Clock),
    .reset (Reset),
    .clear (timer_clear),
    .tick  (tick)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; the end-of-frame decision mirrors the IDLE decision so
  // back-to-back frames only pay the FETCH/LOAD gap.
  always_comb begin
    state_next = state;
    frame_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (EN && !Empty) state_next = FETCH;
      end
      FETCH: state_next = LOAD;
      LOAD:  state_next = START;
      START: begin
        if (tick) state_next = DATA;
      end
      DATA: begin
        if (tick && last_bit) begin
`ifdef FIFO_TX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef FIFO_TX_PARITY_EN
      PARITY: begin
        if (tick) state_next = STOP;
      end
`endif
      STOP: begin
        if (tick && last_stop) begin
          frame_done = 1'b1;
          state_next = (EN && !Empty) ? FETCH : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs depend only on registered state, never directly on inputs.
  always_comb begin
    RE   = (state == FETCH);
    Busy = (state != IDLE);
    Tx   = 1'b1;
    unique case (state)
      START:   Tx = 1'b0;
      DATA:    Tx = shift_reg[0];
`ifdef FIFO_TX_PARITY_EN
      PARITY:  Tx = parity_bit;
`endif
      default: Tx = 1'b1;
    endcase
  end

  // Word capture, shifting and frame accounting.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      shift_reg   <= '0;
      bit_cnt     <= '0;
      stop_cnt    <= 1'b0;
      Frames_Sent <= '0;
`ifdef FIFO_TX_PARITY_EN
      parity_bit  <= 1'b0;
`endif
    end else begin
      if (state == LOAD) begin
        shift_reg  <= Read_Data;
        bit_cnt    <= '0;
        stop_cnt   <= 1'b0;
`ifdef FIFO_TX_PARITY_EN
        parity_bit <= ^Read_Data;
`endif
      end
      if (state == DATA && tick) begin
        shift_reg <= shift_reg >> 1;
        bit_cnt   <= bit_cnt + BIT_CNT_W'(1);
      end
      if (state == STOP && tick) begin
        stop_cnt <= stop_cnt + 1'b1;
      end
      if (frame_done) begin
        Frames_Sent <= Frames_Sent + FRAMES_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_serial_tx.sv
// tb_fifo_serial_tx
// Directed bench for fifo_serial_tx with a small FIFO model feeding it and a
// line decoder that rebuilds each frame from Tx. Honors FIFO_TX_PARITY_EN.
module tb_fifo_serial_tx;

  localparam int CPB = 4;
  localparam int DW  = 16;
  localparam int SB  = 1;
`ifdef FIFO_TX_PARITY_EN
  localparam int PB  = 1;
`else
  localparam int PB  = 0;
`endif
  localparam int FRAME_LEN = (1 + DW + PB + SB) * CPB;

  logic          clk;
  logic          reset;
  logic          en;
  logic          empty;
  logic [DW-1:0] rd_data;
  logic          re;
  logic          tx;
  logic          busy;
  logic [15:0]   frames_sent;

  int checks;
  int errors;
  int cyc;
  int re_pulses;

  // FIFO model: bench pushes, DUT pops through RE.
  logic [DW-1:0] mem [0:63];
  int            wr_ptr;
  int            rd_ptr;

  // Line decoder results.
  logic [DW-1:0] rx_words [0:31];
  bit            rx_ok    [0:31];
  logic          rx_par   [0:31];
  int            rx_start [0:31];
  int            rx_end   [0:31];
  int            rx_count;
  int            mon_aborts;
  bit            m_ok;
  bit            m_ab;
  logic [DW-1:0] m_word;
  logic          m_par;
  int            m_start;

  fifo_serial_tx #(
    .DATA_WIDTH   (DW),
    .CLKS_PER_BIT (CPB),
    .STOP_BITS    (SB)
  ) dut (
    .Clock       (clk),
    .Reset       (reset),
    .EN          (en),
    .Empty       (empty),
    .Read_Data   (rd_data),
    .RE          (re),
    .Tx          (tx),
    .Busy        (busy),
    .Frames_Sent (frames_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign empty = (wr_ptr == rd_ptr);

  initial begin
    rd_ptr  = 0;
    rd_data = '0;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (re === 1'b1) begin
      rd_data <= mem[rd_ptr[5:0]];
      rd_ptr  <= rd_ptr + 1;
    end
  end

  always @(negedge clk) begin
    if (re === 1'b1) re_pulses <= re_pulses + 1;
  end

  // Decoder: a low level on an idle line starts a frame; each bit is taken
  // from its first cycle and must hold for the whole bit period.
  initial begin
    rx_count   = 0;
    mon_aborts = 0;
    forever begin
      @(negedge clk);
      if (tx === 1'b0 && reset === 1'b0) begin
        m_ok    = 1'b1;
        m_ab    = 1'b0;
        m_word  = '0;
        m_par   = 1'b0;
        m_start = cyc;
        for (int c = 1; c < CPB; c++) begin
          @(negedge clk);
          if (reset === 1'b1) m_ab = 1'b1;
          if (tx !== 1'b0) m_ok = 1'b0;
        end
        for (int b = 0; b < DW; b++) begin
          for (int c = 0; c < CPB; c++) begin
            @(negedge clk);
            if (reset === 1'b1) m_ab = 1'b1;
            if (c == 0) m_word[b] = tx;
            else if (tx !== m_word[b]) m_ok = 1'b0;
          end
        end
        for (int c = 0; c < PB * CPB; c++) begin
          @(negedge clk);
          if (reset === 1'b1) m_ab = 1'b1;
          if (c == 0) m_par = tx;
          else if (tx !== m_par) m_ok = 1'b0;
        end
        for (int c = 0; c < SB * CPB; c++) begin
          @(negedge clk);
          if (reset === 1'b1) m_ab = 1'b1;
          if (tx !== 1'b1) m_ok = 1'b0;
        end
        if (m_ab) begin
          mon_aborts = mon_aborts + 1;
        end else begin
          rx_words[rx_count] = m_word;
          rx_ok[rx_count]    = m_ok;
          rx_par[rx_count]   = m_par;
          rx_start[rx_count] = m_start;
          rx_end[rx_count]   = cyc;
          rx_count           = rx_count + 1;
        end
      end
    end
  end

  task automatic push(input logic [DW-1:0] w);
    mem[wr_ptr[5:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic reset_dut;
    @(negedge clk);
    reset = 1'b1;
    en    = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_done(input int target, input int limit, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (frames_sent == 16'(target) && busy === 1'b0) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    int re0, tx_bad, busy_bad;
    reset = 1'b1;
    en    = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (tx !== 1'b1) begin errors++; $display("[TB] FAIL reset_tx got %b exp 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b exp 0", busy); end
    checks++; if (re !== 1'b0) begin errors++; $display("[TB] FAIL reset_re got %b exp 0", re); end
    checks++; if (frames_sent !== 16'h0000) begin errors++; $display("[TB] FAIL reset_frames got %h exp 0000", frames_sent); end
    reset = 1'b0;
    en    = 1'b1;
    re0 = re_pulses; tx_bad = 0; busy_bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx !== 1'b1) tx_bad++;
      if (busy !== 1'b0) busy_bad++;
    end
    checks++; if (re_pulses - re0 != 0) begin errors++; $display("[TB] FAIL empty_re_pulses got %0d exp 0", re_pulses - re0); end
    checks++; if (tx_bad != 0) begin errors++; $display("[TB] FAIL empty_tx_low_cycles got %0d exp 0", tx_bad); end
    checks++; if (busy_bad != 0) begin errors++; $display("[TB] FAIL empty_busy_cycles got %0d exp 0", busy_bad); end
    checks++; if (frames_sent !== 16'h0000) begin errors++; $display("[TB] FAIL empty_frames got %h exp 0000", frames_sent); end
  endtask

  task automatic test_single;
    int n0, re0;
    reset_dut();
    n0 = rx_count; re0 = re_pulses;
    en = 1'b1;
    push(16'h0100);
    @(negedge clk);
    checks++; if (re !== 1'b1) begin errors++; $display("[TB] FAIL single_fetch_re got %b exp 1", re); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL single_fetch_busy got %b exp 1", busy); end
    @(negedge clk);
    checks++; if (re !== 1'b0 || tx !== 1'b1) begin errors++; $display("[TB] FAIL single_load re=%b tx=%b exp re=0 tx=1", re, tx); end
    @(negedge clk);
    checks++; if (tx !== 1'b0) begin errors++; $display("[TB] FAIL single_start_tx got %b exp 0", tx); end
    repeat (FRAME_LEN - 1) @(negedge clk);
    checks++; if (frames_sent !== 16'h0000 || tx !== 1'b1) begin errors++; $display("[TB] FAIL single_last_stop frames=%h tx=%b exp 0000/1", frames_sent, tx); end
    @(negedge clk);
    checks++; if (frames_sent !== 16'h0001) begin errors++; $display("[TB] FAIL single_frames got %h exp 0001", frames_sent); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL single_busy_end got %b exp 0", busy); end
    checks++; if (rx_count != n0 + 1) begin errors++; $display("[TB] FAIL single_rx_count got %0d exp %0d", rx_count, n0 + 1); end
    checks++; if (rx_words[n0] !== 16'h0100 || !rx_ok[n0]) begin errors++; $display("[TB] FAIL single_word got %h ok=%b exp 0100 ok=1", rx_words[n0], rx_ok[n0]); end
    checks++; if (rx_end[n0] - rx_start[n0] + 1 != FRAME_LEN) begin errors++; $display("[TB] FAIL single_len got %0d exp %0d", rx_end[n0] - rx_start[n0] + 1, FRAME_LEN); end
    checks++; if (re_pulses - re0 != 1) begin errors++; $display("[TB] FAIL single_re_pulses got %0d exp 1", re_pulses - re0); end
  endtask

  task automatic test_back_to_back;
    logic [DW-1:0] exp_w [0:2];
    int n0, re0;
    bit to;
    exp_w[0] = 16'h1050; exp_w[1] = 16'h2000; exp_w[2] = 16'h4800;
    reset_dut();
    n0 = rx_count; re0 = re_pulses;
    en = 1'b1;
    for (int i = 0; i < 3; i++) push(exp_w[i]);
    wait_done(3, 20 * FRAME_LEN, to);
    checks++; if (to) begin errors++; $display("[TB] FAIL b2b_timeout frames=%h busy=%b exp 0003/0", frames_sent, busy); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (rx_words[n0+i] !== exp_w[i] || !rx_ok[n0+i]) begin errors++; $display("[TB] FAIL b2b_word%0d got %h ok=%b exp %h", i, rx_words[n0+i], rx_ok[n0+i], exp_w[i]); end
    end
    for (int i = 0; i < 2; i++) begin
      checks++; if (rx_start[n0+i+1] - rx_end[n0+i] != 3) begin errors++; $display("[TB] FAIL b2b_gap%0d got %0d exp 2", i, rx_start[n0+i+1] - rx_end[n0+i] - 1); end
    end
    checks++; if (frames_sent !== 16'h0003) begin errors++; $display("[TB] FAIL b2b_frames got %h exp 0003", frames_sent); end
    checks++; if (empty !== 1'b1 || re_pulses - re0 != 3) begin errors++; $display("[TB] FAIL b2b_drain empty=%b re=%0d exp 1/3", empty, re_pulses - re0); end
  endtask

`ifdef FIFO_TX_PARITY_EN
  task automatic test_parity;
    logic [DW-1:0] exp_w [0:1];
    logic          exp_p;
    int n0;
    bit to;
    exp_w[0] = 16'h0100; exp_w[1] = 16'h6835;
    reset_dut();
    n0 = rx_count;
    en = 1'b1;
    push(exp_w[0]);
    push(exp_w[1]);
    wait_done(2, 20 * FRAME_LEN, to);
    checks++; if (to) begin errors++; $display("[TB] FAIL parity_timeout frames=%h exp 0002", frames_sent); end
    for (int i = 0; i < 2; i++) begin
      exp_p = ^exp_w[i];
      checks++; if (rx_par[n0+i] !== exp_p) begin errors++; $display("[TB] FAIL parity_bit%0d got %b exp %b", i, rx_par[n0+i], exp_p); end
      checks++; if (rx_words[n0+i] !== exp_w[i] || !rx_ok[n0+i]) begin errors++; $display("[TB] FAIL parity_word%0d got %h exp %h", i, rx_words[n0+i], exp_w[i]); end
      checks++; if (rx_end[n0+i] - rx_start[n0+i] + 1 != 76) begin errors++; $display("[TB] FAIL parity_len%0d got %0d exp 76", i, rx_end[n0+i] - rx_start[n0+i] + 1); end
    end
  endtask
`endif

  task automatic test_en_drop;
    logic [DW-1:0] exp_w [0:3];
    int n0, re0;
    bit to;
    exp_w[0] = 16'h1234; exp_w[1] = 16'h5678; exp_w[2] = 16'h9ABC; exp_w[3] = 16'hDEF0;
    reset_dut();
    n0 = rx_count; re0 = re_pulses;
    en = 1'b1;
    for (int i = 0; i < 4; i++) push(exp_w[i]);
    to = 1'b1;
    for (int i = 0; i < 4 * FRAME_LEN; i++) begin
      @(negedge clk);
      if (frames_sent == 16'h0001) begin to = 1'b0; break; end
    end
    checks++; if (to) begin errors++; $display("[TB] FAIL endrop_first_timeout frames=%h exp 0001", frames_sent); end
    repeat (20) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL endrop_busy_mid got %b exp 1", busy); end
    en = 1'b0;
    wait_done(2, 4 * FRAME_LEN, to);
    checks++; if (to) begin errors++; $display("[TB] FAIL endrop_second_timeout frames=%h exp 0002", frames_sent); end
    repeat (30) @(negedge clk);
    checks++; if (frames_sent !== 16'h0002 || busy !== 1'b0) begin errors++; $display("[TB] FAIL endrop_hold frames=%h busy=%b exp 0002/0", frames_sent, busy); end
    checks++; if (re_pulses - re0 != 2) begin errors++; $display("[TB] FAIL endrop_hold_re got %0d exp 2", re_pulses - re0); end
    en = 1'b1;
    wait_done(4, 10 * FRAME_LEN, to);
    checks++; if (to) begin errors++; $display("[TB] FAIL endrop_resume_timeout frames=%h exp 0004", frames_sent); end
    checks++; if (rx_count != n0 + 4 || re_pulses - re0 != 4) begin errors++; $display("[TB] FAIL endrop_counts rx=%0d re=%0d exp 4/4", rx_count - n0, re_pulses - re0); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (rx_words[n0+i] !== exp_w[i] || !rx_ok[n0+i]) begin errors++; $display("[TB] FAIL endrop_word%0d got %h exp %h", i, rx_words[n0+i], exp_w[i]); end
    end
  endtask

  task automatic test_reset_mid;
    int n0, ab0;
    bit to;
    reset_dut();
    n0 = rx_count; ab0 = mon_aborts;
    en = 1'b1;
    push(16'h4115);
    to = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx === 1'b0) begin to = 1'b0; break; end
    end
    checks++; if (to) begin errors++; $display("[TB] FAIL rstmid_no_start tx=%b exp 0", tx); end
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (tx !== 1'b1 || busy !== 1'b0 || re !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_outputs tx=%b busy=%b re=%b exp 1/0/0", tx, busy, re); end
    checks++; if (frames_sent !== 16'h0000) begin errors++; $display("[TB] FAIL rstmid_frames got %h exp 0000", frames_sent); end
    reset = 1'b0;
    repeat (100) @(negedge clk);
    checks++; if (mon_aborts - ab0 != 1 || rx_count != n0) begin errors++; $display("[TB] FAIL rstmid_abort aborts=%0d rx=%0d exp 1/0", mon_aborts - ab0, rx_count - n0); end
    push(16'h0070);
    wait_done(1, 4 * FRAME_LEN, to);
    checks++; if (to) begin errors++; $display("[TB] FAIL rstmid_timeout frames=%h exp 0001", frames_sent); end
    checks++; if (rx_words[n0] !== 16'h0070 || !rx_ok[n0]) begin errors++; $display("[TB] FAIL rstmid_word got %h ok=%b exp 0070", rx_words[n0], rx_ok[n0]); end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    re_pulses = 0;
    wr_ptr    = 0;
    reset     = 1'b1;
    en        = 1'b0;
    $display("[TB] start, frame length %0d cycles", FRAME_LEN);
    test_reset();
    test_single();
    test_back_to_back();
`ifdef FIFO_TX_PARITY_EN
    test_parity();
`endif
    test_en_drop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
